// File: rtl/stopwatch_display_scan.sv
// Six-digit multiplexed seven-segment driver for the stopwatch BCD outputs.
// Shows a per-frame snapshot of the time, with lap hold, anti-ghost blanking and leading-zero blanking.
module stopwatch_display_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 2,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] hr_tens,
    input  logic       hold,
    input  logic       lz_en,
    input  logic       colon_on,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       idx;
    logic [5:0][3:0]  snapshot;

    logic       slot_end;
    logic       frame_end;
    logic [3:0] cur_digit;
    logic       dark;
    logic [5:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    assign slot_end  = (scan_cnt == SLOT_LAST);
    assign frame_end = slot_end && (idx == 3'd5);

    // Digit currently being scanned; idx never reaches 6 or 7.
    always_comb begin
        cur_digit = snapshot[5];
        case (idx)
            3'd0: cur_digit = snapshot[0];
            3'd1: cur_digit = snapshot[1];
            3'd2: cur_digit = snapshot[2];
            3'd3: cur_digit = snapshot[3];
            3'd4: cur_digit = snapshot[4];
            default: cur_digit = snapshot[5];
        endcase
    end

    always_comb begin
        seg_next = 7'b0111111;
        case (cur_digit)
            4'd0: seg_next = 7'b1000000;
            4'd1: seg_next = 7'b1111001;
            4'd2: seg_next = 7'b0100100;
            4'd3: seg_next = 7'b0110000;
            4'd4: seg_next = 7'b0011001;
            4'd5: seg_next = 7'b0010010;
            4'd6: seg_next = 7'b0000010;
            4'd7: seg_next = 7'b1111000;
            4'd8: seg_next = 7'b0000000;
            4'd9: seg_next = 7'b0010000;
            default: seg_next = 7'b0111111;
        endcase
    end

    // A slot goes dark during its guard cycles and when the hours-tens zero is suppressed.
    always_comb begin
        dark    = (scan_cnt < BLANK_END)
                  || ((idx == 3'd5) && lz_en && (cur_digit == 4'd0));
        an_next = dark ? 6'b111111 : ~(6'b000001 << idx);
        dp_next = ~(~dark && colon_on && ((idx == 3'd2) || (idx == 3'd4)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            snapshot <= '0;
            an       <= 6'b111111;
            seg      <= 7'b1111111;
            dp       <= 1'b1;
        end else begin
            scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            // Whole-frame capture keeps the shown time tear-free; hold only matters here.
            if (frame_end && !hold) begin
                snapshot <= {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
            end
            an  <= an_next;
            seg <= dark ? 7'b1111111 : seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Self-checking bench for stopwatch_display_scan with a cycle-position reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_stopwatch_display_scan;

    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sec_ones = 4'd0, sec_tens = 4'd0, min_ones = 4'd0;
    logic [3:0] min_tens = 4'd0, hr_ones = 4'd0, hr_tens = 4'd0;
    logic       hold = 1'b0, lz_en = 1'b0, colon_on = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    stopwatch_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
        .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens),
        .hold(hold), .lz_en(lz_en), .colon_on(colon_on),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Reference model: position p counts cycles since reset release; slot and digit follow by division.
    int         p = 0;
    int         out_p = -1;
    logic [3:0] msnap [6];
    logic [5:0] exp_an = 6'h3f;
    logic [6:0] exp_seg = 7'h7f;
    logic       exp_dp = 1'b1;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (v > 4'd9) ? 7'b0111111 : tab[v];
    endfunction

    always @(posedge clk) begin
        int  slot, d;
        logic dark;
        if (rst) begin
            p = 0; out_p = -1;
            for (int i = 0; i < 6; i++) msnap[i] = 4'd0;
            exp_an = 6'h3f; exp_seg = 7'h7f; exp_dp = 1'b1;
        end else begin
            slot = p % SD;
            d    = (p / SD) % 6;
            dark = (slot < BC) || (d == 5 && lz_en && msnap[5] == 4'd0);
            exp_an  = dark ? 6'h3f : ~(6'd1 << d);
            exp_seg = dark ? 7'h7f : seg_of(msnap[d]);
            exp_dp  = !(!dark && (d == 2 || d == 4) && colon_on);
            out_p   = p;
            if ((p % FRAME) == FRAME - 1 && !hold) begin
                msnap = '{sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens};
            end
            p = p + 1;
        end
    end

    task automatic set_time(input int h, input int m, input int s);
        hr_tens  = 4'(h / 10); hr_ones  = 4'(h % 10);
        min_tens = 4'(m / 10); min_ones = 4'(m % 10);
        sec_tens = 4'(s / 10); sec_ones = 4'(s % 10);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        hold = 1'b0; lz_en = 1'b0; colon_on = 1'b1;
        set_time(0, 0, 0);
        do_reset();
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== 14'h3fff)
            $display("[TB] FAIL reset_blank_first: got %b/%b/%b expected 111111/1111111/1", an, seg, dp);
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {6'b111110, 7'b1000000, 1'b1})
            $display("[TB] FAIL reset_first_lit: got %b/%b/%b expected 111110/1000000/1", an, seg, dp);
        if ({an, seg, dp} !== {6'b111110, 7'b1000000, 1'b1}) errors++;
        @(negedge clk) rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== 14'h3fff) begin
                errors++;
                $display("[TB] FAIL reset_held: got %b/%b/%b expected 111111/1111111/1", an, seg, dp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_time_display();
        logic [13:0] tab [6];
        logic [13:0] want;
        int pp;
        tab = '{{6'b111110, 7'b0000010, 1'b1}, {6'b111101, 7'b0010010, 1'b1},
                {6'b111011, 7'b0011001, 1'b0}, {6'b110111, 7'b0110000, 1'b1},
                {6'b101111, 7'b0100100, 1'b0}, {6'b011111, 7'b1111001, 1'b1}};
        lz_en = 1'b0; colon_on = 1'b1; hold = 1'b0;
        set_time(12, 34, 56);
        do_reset();
        for (int n = 1; n <= 2 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("[TB] FAIL time_model p=%0d: got %b/%b/%b expected %b/%b/%b", n - 1, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (n > FRAME) begin
                pp   = n - 1;
                want = (pp % SD == 0) ? 14'h3fff : tab[(pp - FRAME) / SD];
                checks++;
                if ({an, seg, dp} !== want) begin
                    errors++;
                    $display("[TB] FAIL time_table p=%0d: got %b/%b/%b expected %b", pp, an, seg, dp, want);
                end
            end
        end
    endtask

    task automatic test_hold();
        lz_en = 1'b0; colon_on = 1'b0; hold = 1'b0;
        set_time(0, 0, 7);
        do_reset();
        repeat (FRAME) @(negedge clk);
        hold = 1'b1;
        set_time(0, 0, 9);
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            if (((out_p / SD) % 6) == 0 && (out_p % SD) >= BC) begin
                checks++;
                if ({an, seg} !== {6'b111110, 7'b1111000}) begin
                    errors++;
                    $display("[TB] FAIL hold_frozen p=%0d: got %b/%b expected 111110/1111000", out_p, an, seg);
                end
            end
        end
        hold = 1'b0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("[TB] FAIL hold_model p=%0d: got %b/%b/%b expected %b/%b/%b", out_p, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (n >= FRAME && ((out_p / SD) % 6) == 0 && (out_p % SD) >= BC) begin
                checks++;
                if (seg !== 7'b0010000) begin
                    errors++;
                    $display("[TB] FAIL hold_release p=%0d: got %b expected 0010000", out_p, seg);
                end
            end
        end
    endtask

    task automatic test_invalid_code();
        lz_en = 1'b0; colon_on = 1'b1; hold = 1'b0;
        set_time(21, 0, 48);
        min_tens = 4'hB;
        do_reset();
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("[TB] FAIL invalid_model p=%0d: got %b/%b/%b expected %b/%b/%b", out_p, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (n >= FRAME && ((out_p / SD) % 6) == 3 && (out_p % SD) >= BC) begin
                checks++;
                if ({an, seg} !== {6'b110111, 7'b0111111}) begin
                    errors++;
                    $display("[TB] FAIL invalid_dash p=%0d: got %b/%b expected 110111/0111111", out_p, an, seg);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        lz_en = 1'b1; colon_on = 1'b0; hold = 1'b0;
        set_time(5, 43, 21);
        do_reset();
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            if (n == 2 * FRAME - 1) lz_en = 1'b0;
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("[TB] FAIL lz_model p=%0d: got %b/%b/%b expected %b/%b/%b", out_p, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (n >= FRAME && n < 2 * FRAME && ((out_p / SD) % 6) == 5) begin
                checks++;
                if ({an, seg} !== 13'h1fff) begin
                    errors++;
                    $display("[TB] FAIL lz_blank p=%0d: got %b/%b expected 111111/1111111", out_p, an, seg);
                end
            end
            if (n >= 2 * FRAME && ((out_p / SD) % 6) == 5 && (out_p % SD) >= BC) begin
                checks++;
                if ({an, seg} !== {6'b011111, 7'b1000000}) begin
                    errors++;
                    $display("[TB] FAIL lz_off p=%0d: got %b/%b expected 011111/1000000", out_p, an, seg);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        lz_en = 1'b0; colon_on = 1'b1; hold = 1'b0;
        set_time(55, 55, 55);
        do_reset();
        repeat (FRAME + 3 * SD + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== 14'h3fff) begin
            errors++;
            $display("[TB] FAIL midreset_off: got %b/%b/%b expected 111111/1111111/1", an, seg, dp);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== 14'h3fff) begin
            errors++;
            $display("[TB] FAIL midreset_blank: got %b/%b/%b expected 111111/1111111/1", an, seg, dp);
        end
        for (int n = 0; n < FRAME - 1; n++) begin
            @(negedge clk);
            if ((out_p % SD) >= BC) begin
                checks++;
                if (seg !== 7'b1000000 || an !== ~(6'd1 << (out_p / SD))) begin
                    errors++;
                    $display("[TB] FAIL midreset_zero p=%0d: got %b/%b expected digit %0d showing 1000000", out_p, an, seg, out_p / SD);
                end
            end
        end
    endtask

    task automatic test_random();
        lz_en = 1'b0; colon_on = 1'b0; hold = 1'b0;
        set_time(0, 0, 0);
        do_reset();
        for (int n = 0; n < 20 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("[TB] FAIL random_model p=%0d: got %b/%b/%b expected %b/%b/%b", out_p, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if ($urandom_range(0, 3) == 0) begin
                sec_ones = 4'($urandom_range(0, 15)); sec_tens = 4'($urandom_range(0, 15));
                min_ones = 4'($urandom_range(0, 15)); min_tens = 4'($urandom_range(0, 15));
                hr_ones  = 4'($urandom_range(0, 15));
                hr_tens  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            hold = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 7) == 0) colon_on = ~colon_on;
        end
    endtask

    initial begin
        test_reset();
        test_time_display();
        test_hold();
        test_invalid_code();
        test_leading_zero();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
